// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch unit with an internal PC and a prefetch FIFO.
//
// Reads a byte-wide, combinationally-read instruction memory one byte per
// cycle. It assembles INST_BYTES bytes big-endian into one instruction, then
// buffers complete instructions in a QUEUE_DEPTH-entry FIFO for decode.
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN. When it is defined, a flush
// target is rounded down to an instruction boundary and misalignment is
// flagged on o_misaligned. When it is undefined, o_misaligned is tied to 0.
//
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_flush, i_new_pc  redirect: empty the queue and restart fetch at i_new_pc
//   o_mem_addr         byte address to memory (combinational from state)
//   o_mem_read         fetch strobe (combinational from state)
//   i_mem_data         memory byte for o_mem_addr, same cycle
//   o_inst_ready       queue non-empty
//   i_inst_ack         consumer takes the head entry
//   o_inst, o_inst_pc  head instruction and the address of its first byte
//   o_misaligned       one-cycle pulse after a misaligned redirect
module fetch_queue #(
    parameter int                    ADDR_WIDTH  = 12,
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    INST_BYTES  = 4,
    parameter int                    INST_WIDTH  = INST_BYTES * DATA_WIDTH,
    parameter int                    QUEUE_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic [ADDR_WIDTH-1:0] i_new_pc,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_read,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    output logic                  o_inst_ready,
    input  logic                  i_inst_ack,
    output logic [INST_WIDTH-1:0] o_inst,
    output logic [ADDR_WIDTH-1:0] o_inst_pc,
    output logic                  o_misaligned
);
    localparam int BW = $clog2(INST_BYTES);
    localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CW = $clog2(QUEUE_DEPTH + 1);

    typedef enum logic {FETCH, STALL} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [BW-1:0]         byte_idx;
    logic [INST_WIDTH-1:0] shift;
    logic [INST_WIDTH-1:0] q_inst [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] q_pc   [QUEUE_DEPTH];
    logic [PW-1:0]         head, tail, head_nxt, tail_nxt;
    logic [CW-1:0]         count, count_nxt;

    logic                  last_byte, push, pop;
    logic [INST_WIDTH-1:0] word, head_inst_nxt;
    logic [ADDR_WIDTH-1:0] head_pc_nxt, flush_pc;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return PW'((int'(p) + 1) % QUEUE_DEPTH);
    endfunction

    assign o_mem_read = (state == FETCH);
    assign o_mem_addr = (state == FETCH) ? fetch_pc + ADDR_WIDTH'(byte_idx) : fetch_pc;

`ifdef FETCH_ALIGN_CHECK_EN
    logic [ADDR_WIDTH-1:0] pc_rem;
    assign pc_rem   = i_new_pc % ADDR_WIDTH'(INST_BYTES);
    assign flush_pc = i_new_pc - pc_rem;

    always_ff @(posedge i_clk) begin
        if (i_rst) o_misaligned <= 1'b0;
        else       o_misaligned <= i_flush && (pc_rem != '0);
    end
`else
    assign flush_pc     = i_new_pc;
    assign o_misaligned = 1'b0;
`endif

    always_comb begin
        last_byte = (state == FETCH) && (byte_idx == BW'(INST_BYTES - 1));
        push      = last_byte;
        pop       = o_inst_ready && i_inst_ack;
        // Completed word includes the byte arriving this cycle.
        word      = {shift[INST_WIDTH-DATA_WIDTH-1:0], i_mem_data};
        count_nxt = count + CW'(push) - CW'(pop);
        head_nxt  = pop  ? ptr_inc(head) : head;
        tail_nxt  = push ? ptr_inc(tail) : tail;
        // Registered head view: if the queue drains to nothing but this
        // edge's push, the head entry is the word being written right now.
        head_inst_nxt = '0;
        head_pc_nxt   = '0;
        if (count_nxt != '0) begin
            if (push && (count - CW'(pop)) == '0) begin
                head_inst_nxt = word;
                head_pc_nxt   = fetch_pc;
            end else begin
                head_inst_nxt = q_inst[head_nxt];
                head_pc_nxt   = q_pc[head_nxt];
            end
        end
    end

    // FIFO storage, no reset needed: validity comes from count.
    always_ff @(posedge i_clk) begin
        if (!i_rst && !i_flush && push) begin
            q_inst[tail] <= word;
            q_pc[tail]   <= fetch_pc;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            state        <= FETCH;
            fetch_pc     <= i_rst ? RESET_PC : flush_pc;
            byte_idx     <= '0;
            shift        <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            o_inst_ready <= 1'b0;
            o_inst       <= '0;
            o_inst_pc    <= '0;
        end else begin
            head         <= head_nxt;
            tail         <= tail_nxt;
            count        <= count_nxt;
            o_inst_ready <= (count_nxt != '0);
            o_inst       <= head_inst_nxt;
            o_inst_pc    <= head_pc_nxt;
            case (state)
                FETCH: begin
                    shift <= word;
                    if (last_byte) begin
                        fetch_pc <= fetch_pc + ADDR_WIDTH'(INST_BYTES);
                        byte_idx <= '0;
                        // Only start the next instruction if its push is
                        // guaranteed a free slot.
                        if (count_nxt == CW'(QUEUE_DEPTH)) state <= STALL;
                    end else begin
                        byte_idx <= byte_idx + BW'(1);
                    end
                end
                STALL: if (count_nxt < CW'(QUEUE_DEPTH)) state <= FETCH;
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction fetch unit with an internal program counter and a prefetch queue. It reads a byte-wide, combinationally-read instruction memory one byte per cycle and assembles `INST_BYTES` bytes into an instruction. Completed instructions are buffered in a `QUEUE_DEPTH`-entry FIFO and handed to the decode stage over a ready/ack handshake. It sits between instruction memory and decode. It replaces externally-driven PC stepping with internal sequencing plus a flush/redirect port driven by decode's early jump detection.

## Interface

Parameters:
- `ADDR_WIDTH`, 12, memory address / PC width
- `DATA_WIDTH`, 8, memory data width (one byte per read)
- `INST_BYTES`, 4, bytes per instruction (≥2)
- `INST_WIDTH`, `INST_BYTES*DATA_WIDTH`, assembled instruction width
- `QUEUE_DEPTH`, 4, prefetch FIFO entries (≥1, power of two)
- `RESET_PC`, 0, PC loaded on reset

Ports (one clock; reset is synchronous and active-high):
- `i_clk`  in  1  clock, all state on rising edge
- `i_rst`  in  1  synchronous active-high reset
- `i_flush`  in  1  redirect request, one-cycle qualifier for `i_new_pc`
- `i_new_pc`  in  ADDR_WIDTH  redirect target
- `o_mem_addr`  out  ADDR_WIDTH  byte address to memory
- `o_mem_read`  out  1  high when `o_mem_addr` is a valid fetch
- `i_mem_data`  in  DATA_WIDTH  memory byte for `o_mem_addr`, same cycle
- `o_inst_ready`  out  1  queue non-empty
- `i_inst_ack`  in  1  consumer takes head entry
- `o_inst`  out  INST_WIDTH  head instruction
- `o_inst_pc`  out  ADDR_WIDTH  address of head instruction's first byte
- `o_misaligned`  out  1  misaligned redirect pulse (see Configuration)

## Operation

- State:
  - `fetch_pc`: address of the instruction being assembled.
  - `byte_idx`: 0..INST_BYTES-1.
  - `shift`: shift register holding the partial instruction.
  - FIFO: head/tail pointers and a count (0..QUEUE_DEPTH).
- Fetch engine: two states, FETCH and STALL.
  - FETCH: `o_mem_read`=1 and `o_mem_addr = fetch_pc + byte_idx` (mod 2^ADDR_WIDTH).
  - Each edge in FETCH latches `i_mem_data` into `shift` and increments `byte_idx`.
- Byte order: big-endian. The byte at `fetch_pc` becomes `o_inst[INST_WIDTH-1 -: DATA_WIDTH]`.
- Completion: when `byte_idx == INST_BYTES-1`, on that edge:
  - the assembled word (final byte included) and `fetch_pc` are pushed;
  - `fetch_pc += INST_BYTES` (wraps mod 2^ADDR_WIDTH);
  - `byte_idx` = 0.
- Start gating: byte 0 of a new instruction begins only if count after this edge's pop is < QUEUE_DEPTH; otherwise the engine goes to STALL. Only one instruction is ever in flight, so the push at completion always has a free slot.
- STALL: `o_mem_read`=0 and `o_mem_addr` holds `fetch_pc`. The engine returns to FETCH on the edge where count drops below QUEUE_DEPTH.
- Pop: `o_inst_ready && i_inst_ack` at an edge removes the head. An ack while the queue is empty is ignored.
- Push and pop on the same edge: count is unchanged and both take effect.
- Flush (`i_flush`=1) has priority over push, pop and ack. On that edge:
  - FIFO emptied;
  - `byte_idx` = 0 and the partial word discarded;
  - `fetch_pc` = `i_new_pc`;
  - state = FETCH.
- Empty queue: `o_inst` = 0 and `o_inst_pc` = 0.

## Timing

- Reset values (edge with `i_rst`=1):
  - `fetch_pc`=RESET_PC, queue empty, state FETCH, `byte_idx`=0;
  - `o_inst_ready`=0, `o_inst`=0, `o_inst_pc`=0, `o_misaligned`=0;
  - `o_mem_read`=1, `o_mem_addr`=RESET_PC (first cycle after reset).
- Reset asserted mid-instruction or with a non-empty queue discards everything. Reset overrides flush.
- Latency from reset release or flush to `o_inst_ready`=1 is exactly INST_BYTES cycles.
- Sustained throughput with no stalls is one instruction per INST_BYTES cycles.
- Outputs are registered, except `o_mem_addr` and `o_mem_read`, which are combinational from registered state only. No combinational path from `i_inst_ack` or `i_flush` to any output.
- First fetch after a flush is at `i_new_pc` in the cycle after the flush edge. `o_inst_ready` is 0 in that cycle.

## Configuration

- `FETCH_ALIGN_CHECK_EN` defined:
  - a flush with `i_new_pc % INST_BYTES != 0` loads `fetch_pc` with `i_new_pc` rounded down to a multiple of INST_BYTES;
  - `o_misaligned` is 1 for exactly the cycle after that flush edge, 0 otherwise.
- Not defined: `i_new_pc` is used unmodified and `o_misaligned` is tied to 0.

## Test plan

- Reset then free run, memory: 0:F1 1:42 4:F0 5:88, all other addresses 0, `i_inst_ack` held 1. Required: `o_inst`=F1420000/`o_inst_pc`=0 at cycle 4, then F0880000/4 at cycle 8, then 00000000/8.
- Backpressure, QUEUE_DEPTH=2, ack=0. Required: two entries (pc 0, 4) queue; `o_mem_read`=0 with `o_mem_addr`=8 held. A single ack resumes fetch at 8 on the next cycle.
- Flush with `i_new_pc`=8 after 2 bytes of the pc-4 instruction. Required: queue empty next cycle, fetch at 8,9,10,11, and the head is 8's word after 4 cycles, with no pc-4 entry ever visible.
- Wrap: RESET_PC=FFC (ADDR_WIDTH=12). Required: addresses FFC..FFF, then 000, and the second entry has `o_inst_pc`=000.
- Flush and ack asserted on the same edge with the queue full. Required: queue empty, ack ignored, count 0.
- With `FETCH_ALIGN_CHECK_EN`, flush to 0x00A. Required: fetch starts at 0x008 and `o_misaligned`=1 for one cycle. Without the macro: fetch starts at 0x00A and `o_misaligned`=0.
